// File: rtl/paddle_charge_timer.sv
// TIA paddle pot emulation: one shared scanline counter charges all four
// paddle capacitors, and each INPT bit trips when the count reaches its threshold.
//   state      | meaning
//   ST_DUMPED  | capacitors grounded, count held at 0, all inpt low
//   ST_CHARGE  | counting scanline ticks since dump release
//   ST_SAT     | counter at full scale, ticks ignored until next dump
module paddle_charge_timer #(
    parameter int MIN_LINES = 2,
    parameter bit SIGNED_IN = 1'b0,
    parameter int CNT_W     = 9
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        hsync,
    input  logic        dump,
    input  logic [31:0] pad_pos,
    input  logic [3:0]  pad_en,
    output logic [3:0]  inpt,
    output logic        charging
);

    typedef enum logic [1:0] {
        ST_DUMPED = 2'd0,
        ST_CHARGE = 2'd1,
        ST_SAT    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] MIN_L   = CNT_W'(MIN_LINES);
    localparam logic [7:0]       POS_FLIP = SIGNED_IN ? 8'h80 : 8'h00;

    logic              hs_s1_q, hs_s2_q, hs_s3_q;
    logic              dm_s1_q, dm_s2_q, dm_s3_q;
    logic              line_tick, dump_s, dump_fall;
    state_t            state_q;
    logic [CNT_W-1:0]  count_q;
    logic [3:0][7:0]   pos_l_q;
    logic [3:0][7:0]   pos_conv;
    logic [3:0][CNT_W-1:0] thr;
    logic [3:0]        inpt_q, inpt_d;
    logic              charging_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hs_s1_q <= 1'b0;
            hs_s2_q <= 1'b0;
            hs_s3_q <= 1'b0;
            dm_s1_q <= 1'b0;
            dm_s2_q <= 1'b0;
            dm_s3_q <= 1'b0;
        end else begin
            hs_s1_q <= hsync;
            hs_s2_q <= hs_s1_q;
            hs_s3_q <= hs_s2_q;
            dm_s1_q <= dump;
            dm_s2_q <= dm_s1_q;
            dm_s3_q <= dm_s2_q;
        end
    end

    assign line_tick = hs_s2_q & ~hs_s3_q;
    assign dump_s    = dm_s2_q;
    // Release needs a real high-to-low transition, so coming out of reset with dump low stays dumped.
    assign dump_fall = dm_s3_q & ~dm_s2_q;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pos_conv[i] = pad_pos[8*i +: 8] ^ POS_FLIP;
            thr[i]      = MIN_L + CNT_W'(pos_l_q[i]);
        end
    end

    // A synchronised dump clears the outputs on the same edge the FSM returns to ST_DUMPED.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            inpt_d[i] = pad_en[i] & (state_q != ST_DUMPED) & ~dump_s & (count_q >= thr[i]);
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_DUMPED;
            count_q    <= '0;
            pos_l_q    <= '0;
            charging_q <= 1'b0;
            inpt_q     <= 4'b0000;
        end else begin
            inpt_q <= inpt_d;
            case (state_q)
                ST_DUMPED: begin
                    count_q <= '0;
                    if (dump_fall) begin
                        pos_l_q    <= pos_conv;
                        state_q    <= ST_CHARGE;
                        charging_q <= 1'b1;
                    end
                end
                ST_CHARGE: begin
                    if (dump_s) begin
                        state_q    <= ST_DUMPED;
                        count_q    <= '0;
                        charging_q <= 1'b0;
                    end else if (line_tick) begin
                        count_q <= count_q + CNT_W'(1);
                        if (count_q == CNT_MAX - CNT_W'(1)) begin
                            state_q    <= ST_SAT;
                            charging_q <= 1'b0;
                        end
                    end
                end
                ST_SAT: begin
                    if (dump_s) begin
                        state_q    <= ST_DUMPED;
                        count_q    <= '0;
                        charging_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_DUMPED;
                    count_q    <= '0;
                    charging_q <= 1'b0;
                end
            endcase
        end
    end

    assign inpt     = inpt_q;
    assign charging = charging_q;

endmodule
